// File: rtl/matrix_scan_ctrl_if.sv
// Counter/ADC/control bundle between the matrix scan sequencer (master) and the
// row/column counters, ADC and frame host (slave).
interface matrix_scan_ctrl_if #(
    parameter int ROWS = 4,
    parameter int RW   = 2,
    parameter int CW   = 2
);
    logic            start_i;
    logic            conv_done_i;
    logic [RW-1:0]   row_cnt_i;
    logic [CW-1:0]   col_cnt_i;
    logic [1:0]      opc_row_o;
    logic [1:0]      opc_col_o;
    logic [ROWS-1:0] row_sel_o;
    logic            conv_start_o;
    logic            busy_o;
    logic            frame_done_o;
    logic            err_o;

    modport master (
        input  start_i, conv_done_i, row_cnt_i, col_cnt_i,
        output opc_row_o, opc_col_o, row_sel_o, conv_start_o, busy_o, frame_done_o, err_o
    );

    modport slave (
        output start_i, conv_done_i, row_cnt_i, col_cnt_i,
        input  opc_row_o, opc_col_o, row_sel_o, conv_start_o, busy_o, frame_done_o, err_o
    );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// Bolometer matrix scan sequencer driving row/col counter opcodes; SCAN_TIMEOUT_EN adds a WAIT timeout.
// Latency: CLR + SETTLE_CYC + START + ADC wait + 1 advance cycle per pixel; outputs are Moore decodes.
// Backpressure: none; start_i is dropped while busy, WAIT stalls until conv_done_i (or timeout).
module matrix_scan_ctrl #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int RW          = 2,
    parameter int CW          = 2,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    matrix_scan_ctrl_if.master   bus
);
    localparam logic [1:0] OPC_CLR  = 2'b00;
    localparam logic [1:0] OPC_HOLD = 2'b01;
    localparam logic [1:0] OPC_INC  = 2'b10;
    localparam int         SW       = $clog2(SETTLE_CYC + 1);

    if (SETTLE_CYC < 1 || TIMEOUT_CYC < 1 || ROWS < 2 || ROWS > (1 << RW) ||
        COLS < 2 || COLS > (1 << CW)) begin : g_bad_param
        $error("matrix_scan_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_SETTLE, S_START, S_WAIT, S_NXT_COL, S_NXT_ROW, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q;
    logic          timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Held at zero outside SETTLE so every SETTLE visit starts a fresh count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  settle_q <= '0;
        else if (state_q != S_SETTLE) settle_q <= '0;
        else                          settle_q <= settle_q + SW'(1);
    end

`ifdef SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tout_q;
    logic          err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                tout_q <= '0;
        else if (state_q != S_WAIT) tout_q <= '0;
        else                        tout_q <= tout_q + TW'(1);
    end

    assign timeout = (state_q == S_WAIT) && !bus.conv_done_i &&
                     (tout_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      err_q <= 1'b0;
        else if (timeout) err_q <= 1'b1;
    end

    assign bus.err_o = err_q;
`else
    assign timeout   = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start_i) state_d = S_CLR;
            S_CLR:    state_d = S_SETTLE;
            S_SETTLE: if (settle_q == SW'(SETTLE_CYC - 1)) state_d = S_START;
            S_START:  state_d = S_WAIT;
            // Counter values seen here already reflect the opcode issued before SETTLE.
            S_WAIT: begin
                if (bus.conv_done_i) begin
                    if (bus.col_cnt_i != CW'(COLS - 1))      state_d = S_NXT_COL;
                    else if (bus.row_cnt_i != RW'(ROWS - 1)) state_d = S_NXT_ROW;
                    else                                     state_d = S_DONE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_NXT_COL: state_d = S_SETTLE;
            S_NXT_ROW: state_d = S_SETTLE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        logic row_en;
        row_en           = 1'b0;
        bus.opc_row_o    = OPC_HOLD;
        bus.opc_col_o    = OPC_HOLD;
        bus.conv_start_o = 1'b0;
        bus.busy_o       = 1'b1;
        bus.frame_done_o = 1'b0;
        bus.row_sel_o    = '0;
        case (state_q)
            S_IDLE:    bus.busy_o = 1'b0;
            S_CLR: begin
                bus.opc_row_o = OPC_CLR;
                bus.opc_col_o = OPC_CLR;
            end
            S_SETTLE:  row_en = 1'b1;
            S_START: begin
                row_en           = 1'b1;
                bus.conv_start_o = 1'b1;
            end
            S_WAIT:    row_en = 1'b1;
            S_NXT_COL: bus.opc_col_o = OPC_INC;
            S_NXT_ROW: begin
                bus.opc_row_o = OPC_INC;
                bus.opc_col_o = OPC_CLR;
            end
            S_DONE:    bus.frame_done_o = 1'b1;
            default:   bus.busy_o = 1'b0;
        endcase
        if (row_en) begin
            for (int i = 0; i < ROWS; i++) begin
                if (bus.row_cnt_i == RW'(i)) bus.row_sel_o[i] = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: modelled row/col counters and ADC; expected events are queued
// by the stimulus and popped by a negedge monitor.
module tb_matrix_scan_ctrl;
    localparam int ROWS = 4, COLS = 4, RW = 2, CW = 2, SETTLE_CYC = 2, TIMEOUT_CYC = 16;
    localparam logic [1:0] OPC_CLR = 2'b00, OPC_HOLD = 2'b01, OPC_INC = 2'b10;
    localparam int EV_CLR = 0, EV_CONV = 1, EV_NCOL = 2, EV_NROW = 3, EV_DONE = 4;

    typedef struct {
        int              kind;
        logic [ROWS-1:0] row_sel;
        logic [3:0]      opc;
        int              row;
        int              col;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  run_len = 0;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          adc_en = 1'b1;
    logic          adc_done = 1'b0;
    logic          spur_done = 1'b0;
    logic [RW-1:0] mrow = 2'd2;
    logic [CW-1:0] mcol = 2'd1;

    matrix_scan_ctrl_if #(.ROWS(ROWS), .RW(RW), .CW(CW)) bus ();

    matrix_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW),
        .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    assign bus.conv_done_i = adc_done | spur_done;
    assign bus.row_cnt_i   = mrow;
    assign bus.col_cnt_i   = mcol;

    always #5 clk_i = ~clk_i;

    // Counters are not reset by rst_ni; only a clear opcode zeroes them.
    always @(posedge clk_i) begin
        case (bus.opc_row_o)
            OPC_HOLD: mrow <= mrow;
            OPC_INC:  mrow <= mrow + 2'd1;
            default:  mrow <= '0;
        endcase
        case (bus.opc_col_o)
            OPC_HOLD: mcol <= mcol;
            OPC_INC:  mcol <= mcol + 2'd1;
            default:  mcol <= '0;
        endcase
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (bus.conv_start_o && adc_en) begin
                repeat (3) @(posedge clk_i);
                #1 adc_done = 1'b1;
                @(posedge clk_i);
                #1 adc_done = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            int  kind;
            bit  ev;
            bit  bad;
            ev_t e;
            ev   = 1'b1;
            kind = -1;
            if (bus.conv_start_o)              kind = EV_CONV;
            else if (bus.frame_done_o)         kind = EV_DONE;
            else if (bus.opc_row_o == OPC_INC) kind = EV_NROW;
            else if (bus.opc_row_o == OPC_CLR) kind = EV_CLR;
            else if (bus.opc_col_o == OPC_INC) kind = EV_NCOL;
            else                               ev = 1'b0;
            if (ev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: event kind %0d, none expected", kind);
                end else begin
                    e   = exp_q.pop_front();
                    bad = (kind != e.kind) || (bus.row_sel_o !== e.row_sel) ||
                          ({bus.opc_row_o, bus.opc_col_o} !== e.opc) ||
                          (kind == EV_CONV && (int'(mrow) != e.row || int'(mcol) != e.col));
                    if (bad) begin
                        n_bad++;
                        $display("FAIL sb_event: got kind %0d sel %b opc %b cnt %0d/%0d, expected kind %0d sel %b opc %b cnt %0d/%0d",
                                 kind, bus.row_sel_o, {bus.opc_row_o, bus.opc_col_o}, mrow, mcol,
                                 e.kind, e.row_sel, e.opc, e.row, e.col);
                    end
                end
            end
            if (bus.conv_start_o) check("settle_len", run_len, SETTLE_CYC);
            if (bus.row_sel_o != '0 && !bus.conv_start_o) run_len++;
            else                                          run_len = 0;
        end else begin
            run_len = 0;
        end
    end

    task automatic push_ev(input int kind, input int r, input int c);
        ev_t e;
        e.kind    = kind;
        e.row     = r;
        e.col     = c;
        e.row_sel = '0;
        e.opc     = {OPC_HOLD, OPC_HOLD};
        case (kind)
            EV_CONV: e.row_sel[r] = 1'b1;
            EV_CLR:  e.opc = {OPC_CLR, OPC_CLR};
            EV_NCOL: e.opc = {OPC_HOLD, OPC_INC};
            EV_NROW: e.opc = {OPC_INC, OPC_CLR};
            default: ;
        endcase
        exp_q.push_back(e);
    endtask

    task automatic push_frame();
        push_ev(EV_CLR, 0, 0);
        for (int p = 0; p < ROWS * COLS; p++) begin
            push_ev(EV_CONV, p / COLS, p % COLS);
            if (p == ROWS * COLS - 1)     push_ev(EV_DONE, 0, 0);
            else if (p % COLS == COLS - 1) push_ev(EV_NROW, 0, 0);
            else                          push_ev(EV_NCOL, 0, 0);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk_i);
        #1 bus.start_i = 1'b1;
        @(posedge clk_i);
        #1 bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk_i);
            if (bus.frame_done_o) break;
            n++;
            if (n >= budget) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: no frame_done within %0d cycles", name, budget);
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk_i);
            if (!bus.busy_o) break;
            n++;
            if (n >= budget) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: busy still high after %0d cycles", name, budget);
                break;
            end
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_opc"}, {bus.opc_row_o, bus.opc_col_o}, {OPC_HOLD, OPC_HOLD});
        check({name, "_sel"}, bus.row_sel_o, '0);
        check({name, "_ctl"}, {bus.conv_start_o, bus.busy_o, bus.frame_done_o}, 3'b000);
    endtask

    task automatic inject_spurs();
        int n;
        n = 0;
        while (bus.opc_col_o != OPC_INC) begin
            @(negedge clk_i);
            n++;
            if (n > 60) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spur_sync: no column advance within 60 cycles");
                return;
            end
        end
        @(posedge clk_i);
        #1 spur_done = 1'b1;
        @(posedge clk_i);
        #1 spur_done = 1'b0;
        @(negedge clk_i);
        check("settle_spur_no_start", bus.conv_start_o, 1'b0);
        @(posedge clk_i);
        #1 spur_done = 1'b1;
        @(negedge clk_i);
        check("start_after_settle", bus.conv_start_o, 1'b1);
        @(posedge clk_i);
        #1 spur_done = 1'b0;
        @(negedge clk_i);
        check("coincident_done_ignored", {bus.opc_row_o, bus.opc_col_o}, {OPC_HOLD, OPC_HOLD});
        check("coincident_sel_held", bus.row_sel_o, 4'b0001);
    endtask

    initial begin
        bus.start_i = 1'b0;
        @(negedge clk_i);
        check_idle("reset");
        check("reset_err", bus.err_o, 1'b0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check_idle("idle_hold");
        end

        // Frame 1 with a stray start_i while busy.
        push_frame();
        pulse_start();
        repeat (20) @(posedge clk_i);
        #1 bus.start_i = 1'b1;
        @(posedge clk_i);
        #1 bus.start_i = 1'b0;
        wait_done(400, "frame1_done");

        // Frame 2 requested the cycle after frame_done_o.
        push_frame();
        @(posedge clk_i);
        #1 bus.start_i = 1'b1;
        @(negedge clk_i);
        check("busy_after_done", bus.busy_o, 1'b0);
        @(posedge clk_i);
        #1 bus.start_i = 1'b0;
        fork
            wait_done(400, "frame2_done");
            inject_spurs();
        join

        // ADC stops answering.
        adc_en = 1'b0;
`ifdef SCAN_TIMEOUT_EN
        push_ev(EV_CLR, 0, 0);
        push_ev(EV_CONV, 0, 0);
        pulse_start();
        wait_idle(60, "timeout_idle");
        check("timeout_err", bus.err_o, 1'b1);
        check("timeout_busy", bus.busy_o, 1'b0);
        push_ev(EV_CLR, 0, 0);
        push_ev(EV_CONV, 0, 0);
        pulse_start();
        repeat (5) @(negedge clk_i);
        check("err_sticky_busy", bus.err_o, 1'b1);
        wait_idle(60, "timeout2_idle");
        check("err_sticky_idle", bus.err_o, 1'b1);
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1 check("err_cleared_by_reset", bus.err_o, 1'b0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        adc_en = 1'b1;
`else
        push_frame();
        pulse_start();
        repeat (50) @(negedge clk_i);
        check("stall_busy", bus.busy_o, 1'b1);
        check("stall_err", bus.err_o, 1'b0);
        check("stall_sel", bus.row_sel_o, 4'b0001);
        check("stall_opc", {bus.opc_row_o, bus.opc_col_o}, {OPC_HOLD, OPC_HOLD});
        @(posedge clk_i);
        #1 adc_en = 1'b1;
        spur_done = 1'b1;
        @(posedge clk_i);
        #1 spur_done = 1'b0;
        wait_done(400, "stall_frame_done");
`endif

        // Reset asserted mid-frame, during SETTLE.
        push_ev(EV_CLR, 0, 0);
        pulse_start();
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 check_idle("async_reset");
        check("async_reset_err", bus.err_o, 1'b0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            check_idle("post_reset_idle");
        end

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
